// File: rtl/div_iter.sv
// div_iter: iterative restoring divider (signed/unsigned) with divide-by-zero path and annul
module div_iter #(
    parameter int N_WIDTH = 32,
    parameter int N_CNT   = $clog2(N_WIDTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_signed,
    input  logic               i_annul,
    input  logic [N_WIDTH-1:0] i_dividend,
    input  logic [N_WIDTH-1:0] i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [N_WIDTH-1:0] o_quotient,
    output logic [N_WIDTH-1:0] o_remainder,
    output logic               o_div_zero
);
    localparam int W = N_WIDTH;
    localparam logic [N_CNT-1:0] CNT_LAST = N_CNT'(W - 1);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

    state_t         state_q;
    logic [N_CNT-1:0] cnt_q;
    logic [2*W:0]   work_q, work_d;
    logic [W-1:0]   dvsr_q, quo_q, rem_q;
    logic           q_neg_q, r_neg_q, dz_q, divz_q;
    logic           a_neg, b_neg, b_zero, ge, end_ok;
    logic [W-1:0]   a_mag, b_mag, q_mag, r_mag, q_fin, r_fin;
    logic [W+1:0]   diff;

    // operand magnitudes at capture, one shift-subtract step, and sign-corrected result
    always_comb begin
        a_neg  = i_signed & i_dividend[W-1];
        b_neg  = i_signed & i_divisor[W-1];
        a_mag  = a_neg ? -i_dividend : i_dividend;
        b_mag  = b_neg ? -i_divisor : i_divisor;
        b_zero = i_divisor == '0;
        diff   = work_q[2*W:W-1] - {2'b0, dvsr_q};
        ge     = ~diff[W+1];
        work_d = {ge ? diff[W:0] : work_q[2*W-1:W-1], work_q[W-2:0], ge};
        q_mag  = work_q[W-1:0];
        r_mag  = work_q[2*W-1:W];
        q_fin  = dz_q ? '0 : (q_neg_q ? -q_mag : q_mag);
        r_fin  = dz_q ? work_q[W-1:0] : (r_neg_q ? -r_mag : r_mag);
        end_ok = (state_q == DIV_END) & ~i_annul;
    end

    // the result is presented in DIV_END itself and latched at its end unless annulled
    assign o_busy      = state_q != IDLE;
    assign o_done      = end_ok;
    assign o_quotient  = end_ok ? q_fin : quo_q;
    assign o_remainder = end_ok ? r_fin : rem_q;
    assign o_div_zero  = end_ok ? dz_q : divz_q;

    // control FSM and datapath registers; a zero divisor keeps the raw dividend for the remainder
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start && !i_annul) begin
                    dvsr_q  <= b_mag;
                    q_neg_q <= a_neg ^ b_neg;
                    r_neg_q <= a_neg;
                    dz_q    <= b_zero;
                    cnt_q   <= '0;
                    work_q  <= {{(W+1){1'b0}}, b_zero ? i_dividend : a_mag};
                    state_q <= b_zero ? DIV_ZERO : DIV_ON;
                end
                DIV_ZERO: state_q <= i_annul ? IDLE : DIV_END;
                DIV_ON: if (i_annul) begin
                    state_q <= IDLE;
                end else begin
                    work_q  <= work_d;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= (cnt_q == CNT_LAST) ? DIV_END : DIV_ON;
                end
                DIV_END: begin
                    state_q <= IDLE;
                    if (!i_annul) begin
                        quo_q  <= q_fin;
                        rem_q  <= r_fin;
                        divz_q <= dz_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed checks of div_iter at 32 and 8 bits
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst_n, start, sgn, annul, busy, done, dz;
    logic [31:0] a, b, q, r;
    logic        start8, sgn8, annul8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    div_iter #(.N_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn), .i_annul(annul),
        .i_dividend(a), .i_divisor(b), .o_busy(busy), .o_done(done),
        .o_quotient(q), .o_remainder(r), .o_div_zero(dz)
    );

    div_iter #(.N_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_signed(sgn8), .i_annul(annul8),
        .i_dividend(a8), .i_divisor(b8), .o_busy(busy8), .o_done(done8),
        .o_quotient(q8), .o_remainder(r8), .o_div_zero(dz8)
    );

    task automatic launch32(input logic s, input logic [31:0] x, input logic [31:0] y);
        sgn = s; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait32(output int lat, output logic busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        forever begin
            if (!busy) busy_ok = 1'b0;
            if (done || lat >= 100) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (q !== 32'h0) $display("FAIL reset_q got %h want 0", q); else passed++;
        total++; if (r !== 32'h0) $display("FAIL reset_r got %h want 0", r); else passed++;
        total++; if (dz !== 1'b0) $display("FAIL reset_dz got %b want 0", dz); else passed++;
        total++; if ({busy8, done8, q8, r8, dz8} !== 19'h0) $display("FAIL reset_8bit got %h want 0", {busy8, done8, q8, r8, dz8}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat; logic ok;
        launch32(1'b0, 32'd100, 32'd7);
        wait32(lat, ok);
        total++; if (lat !== 33) $display("FAIL u_latency got %0d want 33", lat); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL u_busy_span got %b want 1", ok); else passed++;
        total++; if (q !== 32'd14) $display("FAIL u_q got %0d want 14", q); else passed++;
        total++; if (r !== 32'd2) $display("FAIL u_r got %0d want 2", r); else passed++;
        total++; if (dz !== 1'b0) $display("FAIL u_dz got %b want 0", dz); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL u_after busy/done got %b%b want 00", busy, done); else passed++;
        total++; if (q !== 32'd14 || r !== 32'd2) $display("FAIL u_hold got %0d/%0d want 14/2", q, r); else passed++;
    endtask

    task automatic test_signed;
        int lat; logic ok;
        launch32(1'b1, 32'hFFFFFFF9, 32'd2);
        wait32(lat, ok);
        total++; if (lat !== 33) $display("FAIL s1_latency got %0d want 33", lat); else passed++;
        total++; if (q !== 32'hFFFFFFFD) $display("FAIL s1_q got %h want fffffffd", q); else passed++;
        total++; if (r !== 32'hFFFFFFFF) $display("FAIL s1_r got %h want ffffffff", r); else passed++;
        @(negedge clk);
        launch32(1'b1, 32'd7, 32'hFFFFFFFE);
        wait32(lat, ok);
        total++; if (q !== 32'hFFFFFFFD) $display("FAIL s2_q got %h want fffffffd", q); else passed++;
        total++; if (r !== 32'd1) $display("FAIL s2_r got %h want 1", r); else passed++;
        @(negedge clk);
        launch32(1'b0, 32'hFFFFFFF9, 32'd2);
        wait32(lat, ok);
        total++; if (q !== 32'h7FFFFFFC || r !== 32'd1) $display("FAIL u_big got %h/%h want 7ffffffc/1", q, r); else passed++;
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int lat; logic ok;
        launch32(1'b0, 32'h12345678, 32'd0);
        wait32(lat, ok);
        total++; if (lat !== 2) $display("FAIL dz_latency got %0d want 2", lat); else passed++;
        total++; if (q !== 32'h0) $display("FAIL dz_q got %h want 0", q); else passed++;
        total++; if (r !== 32'h12345678) $display("FAIL dz_r got %h want 12345678", r); else passed++;
        total++; if (dz !== 1'b1) $display("FAIL dz_flag got %b want 1", dz); else passed++;
        @(negedge clk);
        total++; if (dz !== 1'b1 || busy !== 1'b0) $display("FAIL dz_hold dz/busy got %b%b want 10", dz, busy); else passed++;
        launch32(1'b1, 32'hFFFFFFF9, 32'd0);
        wait32(lat, ok);
        total++; if (q !== 32'h0 || r !== 32'hFFFFFFF9) $display("FAIL dz_signed got %h/%h want 0/fffffff9", q, r); else passed++;
        @(negedge clk);
        launch32(1'b0, 32'd9, 32'd4);
        wait32(lat, ok);
        total++; if (dz !== 1'b0) $display("FAIL dz_clear got %b want 0", dz); else passed++;
        total++; if (q !== 32'd2 || r !== 32'd1) $display("FAIL dz_next got %0d/%0d want 2/1", q, r); else passed++;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int lat; logic ok;
        launch32(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait32(lat, ok);
        total++; if (q !== 32'h80000000) $display("FAIL ovf_q got %h want 80000000", q); else passed++;
        total++; if (r !== 32'h0 || dz !== 1'b0) $display("FAIL ovf_r_dz got %h/%b want 0/0", r, dz); else passed++;
        @(negedge clk);
    endtask

    task automatic test_annul;
        int lat; logic ok;
        launch32(1'b0, 32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL annul_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL annul_done got %b want 0", done); else passed++;
        total++; if (q !== 32'h80000000 || r !== 32'h0) $display("FAIL annul_hold got %h/%h want 80000000/0", q, r); else passed++;
        launch32(1'b0, 32'd1000, 32'd10);
        wait32(lat, ok);
        total++; if (lat !== 33) $display("FAIL annul_restart_latency got %0d want 33", lat); else passed++;
        total++; if (q !== 32'd100 || r !== 32'd0) $display("FAIL annul_restart got %0d/%0d want 100/0", q, r); else passed++;
        @(negedge clk);
    endtask

    task automatic test_annul_end;
        launch32(1'b0, 32'd50, 32'd5);
        repeat (32) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL annul_end_busy got %b want 1", busy); else passed++;
        annul = 1'b1;
        #1;
        total++; if (done !== 1'b0) $display("FAIL annul_end_done got %b want 0", done); else passed++;
        total++; if (q !== 32'd100) $display("FAIL annul_end_q got %0d want 100", q); else passed++;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        total++; if (busy !== 1'b0 || q !== 32'd100) $display("FAIL annul_end_after busy/q got %b/%0d want 0/100", busy, q); else passed++;
    endtask

    task automatic test_annul_start;
        sgn = 1'b0; a = 32'd5; b = 32'd1; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL annul_start_busy got %b want 0", busy); else passed++;
        repeat (3) @(negedge clk);
        total++; if (q !== 32'd100 || done !== 1'b0) $display("FAIL annul_start_q got %0d/%b want 100/0", q, done); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat; logic ok;
        sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; ok = 1'b1;
        forever begin
            if (!busy8) ok = 1'b0;
            if (done8 || lat >= 50) break;
            start8 = (lat == 3 || lat == 5);
            a8 = 8'd9; b8 = 8'd1;
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        total++; if (lat !== 9) $display("FAIL w8_latency got %0d want 9", lat); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL w8_busy_span got %b want 1", ok); else passed++;
        total++; if (q8 !== 8'd66 || r8 !== 8'd2) $display("FAIL w8_result got %0d/%0d want 66/2", q8, r8); else passed++;
        @(negedge clk);
        total++; if (busy8 !== 1'b0) $display("FAIL w8_idle got %b want 0", busy8); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat; logic ok;
        launch32(1'b0, 32'h55, 32'd0);
        wait32(lat, ok);
        @(negedge clk);
        launch32(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_busy_done got %b%b want 00", busy, done); else passed++;
        total++; if (q !== 32'h0 || r !== 32'h0) $display("FAIL rstmid_qr got %h/%h want 0/0", q, r); else passed++;
        total++; if (dz !== 1'b0) $display("FAIL rstmid_dz got %b want 0", dz); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL rstmid_after got %b want 0", busy); else passed++;
    endtask

    initial begin
        start = 1'b0; sgn = 1'b0; annul = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sgn8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_annul;
        test_annul_end;
        test_annul_start;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
